// File: rtl/dac_raw_sample_play.sv
// Raw DAC burst player: buffers packed 2x16-bit words and plays a fixed-length burst on trigger/sync.
// Optional DAC_RAW_PLAY_ZERO_FILL_EN: underflow slots output zero instead of repeating the last sample.
module dac_raw_sample_play #(
  parameter int g_FIFO_DEPTH  = 16,
  parameter int g_SAMPLE_DIV  = 1,
  parameter int g_NUM_SAMPLES = 40
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  output logic [15:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        i_trigger,
  input  logic        i_start_sync,
  output logic        o_busy,
  output logic        o_underflow
);

  localparam int AW = $clog2(g_FIFO_DEPTH);
  localparam int CW = $clog2(g_NUM_SAMPLES + 1);
  localparam logic [CW-1:0] NUM_LAST = CW'(g_NUM_SAMPLES);
  localparam logic [15:0]   DIV_LAST = 16'(g_SAMPLE_DIV - 1);

  typedef enum logic [1:0] {IDLE, ARMED, PLAY, DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   mem_q [g_FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   div_q, div_d;
  logic [15:0]   pend_q, pend_d;
  logic          pend_vld_q, pend_vld_d;
  logic [15:0]   tdata_q, tdata_d;
  logic          tvalid_q, tvalid_d;
  logic          uf_q, uf_d;
  logic          fifo_empty, fifo_full;
  logic          wr_en, rd_en, slot;
  logic [31:0]   rd_word;

  function automatic logic [15:0] next_div(input logic [15:0] d);
    return (d == DIV_LAST) ? 16'd0 : d + 16'd1;
  endfunction

  function automatic logic [15:0] fill_value(input logic [15:0] last);
`ifdef DAC_RAW_PLAY_ZERO_FILL_EN
    return last & 16'h0000;
`else
    return last;
`endif
  endfunction

  assign fifo_empty    = (wr_ptr_q == rd_ptr_q);
  assign fifo_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                         (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Ready is forced low while reset is held, not just after the first clock.
  assign s_axis_tready = aresetn & ~fifo_full;
  assign wr_en         = s_axis_tvalid & s_axis_tready;
  assign rd_word       = mem_q[rd_ptr_q[AW-1:0]];

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign o_busy        = (state_q == PLAY);
  assign o_underflow   = uf_q;

  always_ff @(posedge aclk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= s_axis_tdata;
    pend_q <= pend_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    tdata_d    = tdata_q;
    tvalid_d   = 1'b0;
    uf_d       = uf_q;
    slot       = 1'b0;
    rd_en      = 1'b0;
    case (state_q)
      IDLE: if (i_trigger) state_d = ARMED;
      ARMED: begin
        if (!i_trigger) begin
          state_d = IDLE;
        end else if (i_start_sync) begin
          // The first slot is emitted on the very edge that enters PLAY.
          state_d = PLAY;
          cnt_d   = '0;
          div_d   = '0;
          uf_d    = 1'b0;
          slot    = 1'b1;
        end
      end
      PLAY: begin
        if (!i_trigger) begin
          state_d    = IDLE;
          pend_vld_d = 1'b0;
        end else if (div_q == 16'd0) begin
          if (cnt_q == NUM_LAST) begin
            state_d    = DONE;
            pend_vld_d = 1'b0;
          end else begin
            slot = 1'b1;
          end
        end else begin
          div_d = next_div(div_q);
        end
      end
      DONE: if (!i_trigger) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (slot) begin
      tvalid_d = 1'b1;
      cnt_d    = cnt_d + CW'(1);
      div_d    = next_div(16'd0);
      if (pend_vld_q) begin
        tdata_d    = pend_q;
        pend_vld_d = 1'b0;
      end else if (!fifo_empty) begin
        rd_en      = 1'b1;
        tdata_d    = rd_word[15:0];
        pend_d     = rd_word[31:16];
        pend_vld_d = 1'b1;
      end else begin
        uf_d    = 1'b1;
        tdata_d = fill_value(tdata_q);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      div_q      <= '0;
      pend_vld_q <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      uf_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_q + (AW+1)'(wr_en);
      rd_ptr_q   <= rd_ptr_q + (AW+1)'(rd_en);
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      pend_vld_q <= pend_vld_d;
      tdata_q    <= tdata_d;
      tvalid_q   <= tvalid_d;
      uf_q       <= uf_d;
    end
  end

endmodule

// File: tb/tb_dac_raw_sample_play.sv
// Bench for dac_raw_sample_play: one instance at one clock per sample, one at four clocks per sample.
module tb_dac_raw_sample_play;

  localparam int N = 40;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        trig = 1'b0;
  logic        sync = 1'b0;
  logic        sel = 1'b0;

  logic        tready1, tvalid1, busy1, uf1, tready4, tvalid4, busy4, uf4;
  logic [15:0] tdata1, tdata4;
  logic        o_tready, o_tvalid, o_busy, o_uf;
  logic [15:0] o_tdata;

  always #5 aclk = ~aclk;

  dac_raw_sample_play #(.g_FIFO_DEPTH(16), .g_SAMPLE_DIV(1), .g_NUM_SAMPLES(N)) u_div1 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid & ~sel), .s_axis_tready(tready1),
    .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid1),
    .i_trigger(trig & ~sel), .i_start_sync(sync & ~sel),
    .o_busy(busy1), .o_underflow(uf1)
  );

  dac_raw_sample_play #(.g_FIFO_DEPTH(16), .g_SAMPLE_DIV(4), .g_NUM_SAMPLES(N)) u_div4 (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid & sel), .s_axis_tready(tready4),
    .m_axis_tdata(tdata4), .m_axis_tvalid(tvalid4),
    .i_trigger(trig & sel), .i_start_sync(sync & sel),
    .o_busy(busy4), .o_underflow(uf4)
  );

  assign o_tready = sel ? tready4 : tready1;
  assign o_tvalid = sel ? tvalid4 : tvalid1;
  assign o_busy   = sel ? busy4   : busy1;
  assign o_uf     = sel ? uf4     : uf1;
  assign o_tdata  = sel ? tdata4  : tdata1;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: FIFO contents as a word queue plus the pending high half.
  logic [31:0] wq [$];
  logic        m_pend_v = 1'b0;
  logic [15:0] m_pend = '0;
  logic [15:0] m_last = '0;
  logic        m_uf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    n_cmp++;
    assert (obs === req) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  function automatic logic [31:0] wk(input int k);
    return {16'(2 * k + 2), 16'(2 * k + 1)};
  endfunction

  task automatic m_reset();
    wq.delete();
    m_pend_v = 1'b0;
    m_last   = '0;
    m_uf     = 1'b0;
  endtask

  task automatic m_slot(output logic [15:0] d);
    logic [31:0] w;
    if (m_pend_v) begin
      d = m_pend;
      m_pend_v = 1'b0;
    end else if (wq.size() > 0) begin
      w = wq.pop_front();
      d = w[15:0];
      m_pend = w[31:16];
      m_pend_v = 1'b1;
    end else begin
      m_uf = 1'b1;
`ifdef DAC_RAW_PLAY_ZERO_FILL_EN
      d = 16'h0000;
`else
      d = m_last;
`endif
    end
    m_last = d;
  endtask

  task automatic push_word(input logic [31:0] w);
    int t = 0;
    while (!o_tready && t < 300) begin
      @(negedge aclk);
      t++;
    end
    chk("push_ready", {31'd0, o_tready}, 32'd1);
    s_tdata  = w;
    s_tvalid = 1'b1;
    @(negedge aclk);
    s_tvalid = 1'b0;
    wq.push_back(w);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_tvalid"}, {31'd0, o_tvalid}, 32'd0);
    chk({tag, "_tdata"},  {16'd0, o_tdata},  32'd0);
    chk({tag, "_busy"},   {31'd0, o_busy},   32'd0);
    chk({tag, "_uf"},     {31'd0, o_uf},     32'd0);
    chk({tag, "_tready"}, {31'd0, o_tready}, 32'd0);
  endtask

  // Arms, starts, and checks one burst cycle by cycle; abort_after>0 drops trigger after that many strobes.
  task automatic run_burst(input int abort_after);
    int div = sel ? 4 : 1;
    int slots = 0;
    logic [15:0] d;
    trig = 1'b1;
    @(negedge aclk);
    sync = 1'b1;
    m_uf = 1'b0;
    @(negedge aclk);
    sync = 1'b0;
    for (int cyc = 0; cyc < N * div; cyc++) begin
      chk("burst_busy", {31'd0, o_busy}, 32'd1);
      chk("burst_tvalid", {31'd0, o_tvalid}, {31'd0, (cyc % div) == 0});
      if ((cyc % div) == 0) begin
        m_slot(d);
        slots++;
      end
      chk("burst_tdata", {16'd0, o_tdata}, {16'd0, m_last});
      chk("burst_uf", {31'd0, o_uf}, {31'd0, m_uf});
      if (abort_after > 0 && slots == abort_after && (cyc % div) == 0) begin
        trig = 1'b0;
        @(negedge aclk);
        m_pend_v = 1'b0;
        chk("abort_busy", {31'd0, o_busy}, 32'd0);
        chk("abort_tvalid", {31'd0, o_tvalid}, 32'd0);
        chk("abort_tdata_hold", {16'd0, o_tdata}, {16'd0, m_last});
        return;
      end
      @(negedge aclk);
    end
    m_pend_v = 1'b0;
    chk("done_busy", {31'd0, o_busy}, 32'd0);
    chk("done_tvalid", {31'd0, o_tvalid}, 32'd0);
    chk("done_uf", {31'd0, o_uf}, {31'd0, m_uf});
    chk("done_tdata_hold", {16'd0, o_tdata}, {16'd0, m_last});
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge aclk);
      chk({tag, "_tvalid"}, {31'd0, o_tvalid}, 32'd0);
      chk({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_rand;
    // Reset state
    #1;
    check_outputs_zero("in_reset");
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    m_reset();
    @(negedge aclk);
    chk("post_reset_tready", {31'd0, o_tready}, 32'd1);
    chk("post_reset_busy", {31'd0, o_busy}, 32'd0);

    // Full 20-word burst with a full FIFO and back-pressure
    for (int k = 0; k < 16; k++) push_word(wk(k));
    chk("fifo_full_tready", {31'd0, o_tready}, 32'd0);
    fork
      begin
        for (int k = 16; k < 20; k++) push_word(wk(k));
      end
      run_burst(0);
    join
    chk("burst1_last", {16'd0, o_tdata}, 32'd40);

    // Sync in DONE is ignored
    sync = 1'b1;
    @(negedge aclk);
    sync = 1'b0;
    check_quiet("sync_in_done", 4);
    trig = 1'b0;
    @(negedge aclk);

    // Sync without trigger is ignored
    sync = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    sync = 1'b0;
    check_quiet("sync_no_trig", 4);

    // Partial prefill: underflow tail
    for (int k = 0; k < 10; k++) push_word(wk(k));
    run_burst(0);
    chk("uf_sticky", {31'd0, o_uf}, 32'd1);
    trig = 1'b0;
    @(negedge aclk);

    // Abort after 11 strobes, then resume from word 6
    for (int k = 0; k < 16; k++) push_word(wk(k));
    fork
      begin
        for (int k = 16; k < 20; k++) push_word(wk(k));
      end
      run_burst(11);
    join
    chk("abort_idle_busy", {31'd0, o_busy}, 32'd0);
    @(negedge aclk);
    chk("resume_head", wq[0], wk(6));
    run_burst(0);
    trig = 1'b0;
    @(negedge aclk);

    // Random data, random fill level
    n_rand = $urandom_range(4, 16);
    for (int k = 0; k < n_rand; k++) push_word($urandom);
    run_burst(0);
    trig = 1'b0;
    @(negedge aclk);

    // Reset mid-burst
    for (int k = 0; k < 8; k++) push_word($urandom);
    trig = 1'b1;
    @(negedge aclk);
    sync = 1'b1;
    @(negedge aclk);
    sync = 1'b0;
    repeat (3) @(negedge aclk);
    chk("pre_reset_busy", {31'd0, o_busy}, 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    m_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("rel_tready", {31'd0, o_tready}, 32'd1);
    chk("rel_busy", {31'd0, o_busy}, 32'd0);
    run_burst(0);
    chk("empty_after_reset_uf", {31'd0, o_uf}, 32'd1);
    trig = 1'b0;
    @(negedge aclk);

    // Divide-by-4 instance
    sel = 1'b1;
    aresetn = 1'b0;
    m_reset();
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    for (int k = 0; k < 16; k++) push_word(wk(k));
    chk("div4_full_tready", {31'd0, o_tready}, 32'd0);
    fork
      begin
        for (int k = 16; k < 20; k++) push_word(wk(k));
      end
      run_burst(0);
    join
    chk("div4_last", {16'd0, o_tdata}, 32'd40);
    trig = 1'b0;
    @(negedge aclk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
